// File: rtl/kw_fifo_ctrl_dff.sv
// Valid/ready FIFO controller for an external 1W/1R flop RAM (sync write, async read).
// Optional almost_full output enabled by defining KW_FIFO_CTRL_ALMOST_FULL_EN.
module kw_fifo_ctrl_dff #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
`ifdef KW_FIFO_CTRL_ALMOST_FULL_EN
  parameter int AF_LEVEL   = DEPTH - 2,
`endif
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  ram_cs_n,
  output logic                  ram_we_n,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
`ifdef KW_FIFO_CTRL_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  push_fire;
  logic                  pop_fire;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  // Gating with reset_n keeps the RAM deselected for as long as reset is held.
  assign push_fire  = push_valid & push_ready & reset_n;
  assign pop_fire   = pop_valid & pop_ready & reset_n;

  assign ram_cs_n    = ~push_fire;
  assign ram_we_n    = ~push_fire;
  assign ram_wr_addr = wr_ptr;
  assign ram_rd_addr = rd_ptr;
  assign ram_data_in = push_data;
  assign pop_data    = ram_data_out;
  assign count       = count_q;

  always_comb begin
    count_nxt = count_q;
    if (push_fire && !pop_fire) begin
      count_nxt = count_q + 1'b1;
    end else if (!push_fire && pop_fire) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
    end
  end

`ifdef KW_FIFO_CTRL_ALMOST_FULL_EN
  localparam logic [CNT_WIDTH-1:0] AF_CNT = CNT_WIDTH'(AF_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_check
    $fatal(1, "kw_fifo_ctrl_dff: AF_LEVEL must be within 1..DEPTH");
  end

  // Registered from the next count so it changes on the same edge as count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= AF_CNT);
    end
  end
`endif

endmodule
